mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the five-stage in-order pipeline, directly downstream of the execute stage and upstream of write-back. It latches the execute-to-memory bus, extracts and aligns load data returned by the synchronous data SRAM (word, byte, halfword and unaligned left/right loads), and forwards the final register-file result to write-back. It also drives a forwarding bus back to decode. A one-entry load-data hold register keeps the result correct when write-back stalls.

## Interface
Parameters: none. Bus widths come from mycpu.h:
- `ES_TO_MS_BUS_WD`, 109: execute-to-memory bus width.
- `MS_TO_WS_BUS_WD`, 70: memory-to-write-back bus width.
- `MS_FWD_BUS_WD`, 38: forwarding bus width.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `ws_allowin` in 1: write-back can accept an instruction.
- `ms_allowin` out 1: this stage can accept an instruction.
- `es_to_ms_valid` in 1: execute stage offers an instruction.
- `es_to_ms_bus` in 109: fields are rt_value[108:77], ld_inst[76:70], gr_we[69], dest[68:64], res[63:32], pc[31:0].
- `ms_to_ws_valid` out 1: instruction offered to write-back.
- `ms_to_ws_bus` out 70: fields are gr_we[69], dest[68:64], final_result[63:32], pc[31:0].
- `data_sram_rdata` in 32: SRAM read word for the address issued in the previous cycle.
- `ms_fwd_bus` out 38: fields are fwd_valid[37], dest[36:32], final_result[31:0].

## Operation
- ld_inst bit order, from bit 6 down to bit 0: lw, lb, lbu, lh, lhu, lwl, lwr. The value is one-hot or all-zero; all-zero means a non-load.
- mem_pos = res[1:0], the byte address low bits. B[n] = the load word's byte n, where byte 0 is bits 7:0.
- Load data source: the held register when hold_flag=1, otherwise data_sram_rdata.
- Result selection:
  - lw: the whole word.
  - lb / lbu: B[mem_pos], sign-extended for lb, zero-extended for lbu.
  - lh / lhu: the upper half if mem_pos[1] else the lower half, sign-extended for lh, zero-extended for lhu. mem_pos[0] is ignored.
  - lwl:
    - pos0: {B0, rt[23:0]}
    - pos1: {B1,B0, rt[15:0]}
    - pos2: {B2,B1,B0, rt[7:0]}
    - pos3: the whole word
  - lwr:
    - pos0: the whole word
    - pos1: {rt[31:24], B3,B2,B1}
    - pos2: {rt[31:16], B3,B2}
    - pos3: {rt[31:8], B3}
  - Non-load: final_result = res.
- Hold logic:
  - hold_flag clears on reset and whenever a new instruction is accepted (es_to_ms_valid && ms_allowin).
  - At the end of a cycle with ms_valid && !ws_allowin && !hold_flag, data_sram_rdata is written into the hold register and hold_flag sets.
  - While hold_flag=1 the hold register is frozen.
- Forwarding: fwd_valid = ms_valid && gr_we. dest and final_result are the same values sent on ms_to_ws_bus.
- No exceptions and no address checks; misaligned lw/lh are not trapped and simply use the rules above.

## Timing
- Reset:
  - ms_valid=0, hold_flag=0.
  - The bus register and hold register clear to 0.
  - Resulting outputs: ms_to_ws_valid=0, ms_allowin=1, ms_fwd_bus=0.
- Handshake:
  - ms_ready_go=1, so the stage never self-stalls.
  - ms_allowin = !ms_valid || ws_allowin.
  - ms_to_ws_valid = ms_valid.
- Register update:
  - When ms_allowin=1, ms_valid <= es_to_ms_valid.
  - The bus register loads only when es_to_ms_valid && ms_allowin, so it holds during a stall.
- Latency:
  - An instruction accepted at edge N is presented to write-back from cycle N+1.
  - Load data is valid combinationally in that same cycle (SRAM address was issued in the execute cycle).
- Stall:
  - The output bus and forwarding bus stay stable for every cycle ws_allowin=0.
  - Load results come from the hold register from the second stall cycle on, even if data_sram_rdata changes.
- Simultaneous events: if the stage is valid with ws_allowin=1 and es_to_ms_valid=1, the new instruction replaces the old one at the same edge and hold_flag clears.
- Bubble: if es_to_ms_valid=0 and ms_allowin=1, ms_valid goes to 0. fwd_valid is 0 in that cycle regardless of stale bus contents.
- Reset mid-stall: the valid instruction is dropped and hold_flag clears; everything is back to reset values the next cycle.

## Test plan
1. Byte and halfword extension, with rdata=0x8844_22F1:
   - lb pos0 -> 0xFFFF_FFF1; lbu pos3 -> 0x0000_0088.
   - lh pos2 -> 0xFFFF_8844; lhu pos0 -> 0x0000_22F1.
2. Unaligned loads, with rdata=0xAABB_CCDD and rt=0x1122_3344:
   - lwl pos1 -> 0xCCDD_3344; lwl pos3 -> 0xAABB_CCDD.
   - lwr pos2 -> 0x1122_AABB; lwr pos0 -> 0xAABB_CCDD.
3. Stall with changing rdata:
   - Setup: lw accepted; ws_allowin=0 for 3 cycles; rdata is 0x1234_5678 in the first cycle, then 0xDEAD_BEEF.
   - Required: final_result stays 0x1234_5678 throughout, and ms_allowin=0 during the stall.
4. Back-to-back flow with ws_allowin=1:
   - Setup: an ALU instruction (res=0x5, gr_we=1, dest=3), then lw (dest=4, rdata=0x9).
   - Required: consecutive cycles show fwd_bus = {1,3,0x5} then {1,4,0x9}.
5. Bubble and store:
   - Setup: es_to_ms_valid=0 after one instruction, and a store with gr_we=0.
   - Required: ms_to_ws_valid=0 and fwd_valid=0 in the bubble cycle; for the store, fwd_valid=0 and final_result=res.
6. Reset asserted during a stalled load:
   - Required: the next cycle has ms_to_ws_valid=0, ms_allowin=1 and fwd_bus=0. A following lw uses live rdata, not stale hold data.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: latches the execute-to-memory bus, aligns SRAM load data and
// forwards the register-file result to write-back and back to decode.
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ws_allowin,
  output logic         ms_allowin,
  input  logic         es_to_ms_valid,
  input  logic [108:0] es_to_ms_bus,
  output logic         ms_to_ws_valid,
  output logic [69:0]  ms_to_ws_bus,
  input  logic [31:0]  data_sram_rdata,
  output logic [37:0]  ms_fwd_bus
);

  localparam int ES_TO_MS_BUS_WD = 109;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_FWD_BUS_WD   = 38;

  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] bus_r;
  logic                       hold_flag;
  logic [31:0]                hold_data;

  logic [31:0] rt_value;
  logic [6:0]  ld_inst;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] res;
  logic [31:0] pc;
  logic [1:0]  mem_pos;
  logic [31:0] word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] final_result;
  logic        accept;

  assign {rt_value, ld_inst, gr_we, dest, res, pc} = bus_r;
  assign mem_pos = res[1:0];

  // Handshake: a transfer happens on an edge where valid && allowin; this
  // stage never self-stalls, so it can take a new instruction whenever it is
  // empty or write-back is taking the current one in the same cycle.
  assign ms_allowin     = !ms_valid || ws_allowin;
  assign ms_to_ws_valid = ms_valid;
  assign accept         = es_to_ms_valid && ms_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid  <= 1'b0;
      bus_r     <= '0;
      hold_flag <= 1'b0;
      hold_data <= '0;
    end else begin
      if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (accept) begin
        bus_r     <= es_to_ms_bus;
        hold_flag <= 1'b0;
      end else if (ms_valid && !ws_allowin && !hold_flag) begin
        // SRAM output may change once the stall starts; capture it once.
        hold_flag <= 1'b1;
        hold_data <= data_sram_rdata;
      end
    end
  end

  assign word = hold_flag ? hold_data : data_sram_rdata;

  always_comb begin
    ld_byte = word[7:0];
    case (mem_pos)
      2'd0: ld_byte = word[7:0];
      2'd1: ld_byte = word[15:8];
      2'd2: ld_byte = word[23:16];
      2'd3: ld_byte = word[31:24];
      default: ld_byte = word[7:0];
    endcase
    ld_half = mem_pos[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    final_result = res;
    case (ld_inst)
      7'b1000000: final_result = word;
      7'b0100000: final_result = {{24{ld_byte[7]}}, ld_byte};
      7'b0010000: final_result = {24'd0, ld_byte};
      7'b0001000: final_result = {{16{ld_half[15]}}, ld_half};
      7'b0000100: final_result = {16'd0, ld_half};
      7'b0000010: begin
        case (mem_pos)
          2'd0: final_result = {word[7:0],  rt_value[23:0]};
          2'd1: final_result = {word[15:0], rt_value[15:0]};
          2'd2: final_result = {word[23:0], rt_value[7:0]};
          default: final_result = word;
        endcase
      end
      7'b0000001: begin
        case (mem_pos)
          2'd1: final_result = {rt_value[31:24], word[31:8]};
          2'd2: final_result = {rt_value[31:16], word[31:16]};
          2'd3: final_result = {rt_value[31:8],  word[31:24]};
          default: final_result = word;
        endcase
      end
      default: final_result = res;
    endcase
  end

  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
  assign ms_fwd_bus   = {ms_valid && gr_we, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed test-plan cases plus randomized traffic
// checked against a behavioural model of the stage.
module tb_mem_stage;

  localparam logic [6:0] LD_LW  = 7'b1000000;
  localparam logic [6:0] LD_LB  = 7'b0100000;
  localparam logic [6:0] LD_LBU = 7'b0010000;
  localparam logic [6:0] LD_LH  = 7'b0001000;
  localparam logic [6:0] LD_LHU = 7'b0000100;
  localparam logic [6:0] LD_LWL = 7'b0000010;
  localparam logic [6:0] LD_LWR = 7'b0000001;
  localparam logic [6:0] LD_NON = 7'b0000000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [108:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [69:0]  ms_to_ws_bus;
  logic [31:0]  data_sram_rdata;
  logic [37:0]  ms_fwd_bus;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_fwd_bus      (ms_fwd_bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // behavioural model: instruction held in the stage and its load word
  logic         m_valid;
  logic [108:0] m_bus;
  logic         m_locked;
  logic [31:0]  m_word;
  logic [31:0]  exp_q[$];

  function automatic logic [108:0] mk_bus(input logic [31:0] rt, input logic [6:0] ld,
                                          input logic we, input logic [4:0] dst,
                                          input logic [31:0] res, input logic [31:0] pc);
    return {rt, ld, we, dst, res, pc};
  endfunction

  function automatic logic [31:0] ref_result(input logic [6:0] ld, input logic [31:0] rt,
                                             input logic [31:0] res, input logic [31:0] w);
    int p;
    logic [31:0] v;
    logic [31:0] keep;
    p = int'(res[1:0]);
    v = res;
    if (ld == LD_LW) v = w;
    else if (ld == LD_LB || ld == LD_LBU) begin
      v = (w >> (8 * p)) & 32'hFF;
      if (ld == LD_LB && v[7]) v = v | 32'hFFFF_FF00;
    end else if (ld == LD_LH || ld == LD_LHU) begin
      v = (w >> (16 * (p / 2))) & 32'hFFFF;
      if (ld == LD_LH && v[15]) v = v | 32'hFFFF_0000;
    end else if (ld == LD_LWL) begin
      keep = (32'd1 << (8 * (3 - p))) - 32'd1;
      v = (w << (8 * (3 - p))) | (rt & keep);
    end else if (ld == LD_LWR) begin
      keep = ~(32'hFFFF_FFFF >> (8 * p));
      v = (w >> (8 * p)) | (rt & keep);
    end
    return v;
  endfunction

  // driver: apply inputs mid-cycle and compare outputs against the model
  task automatic drive(input logic v, input logic [108:0] b, input logic wa,
                       input logic [31:0] rd, input logic rst);
    logic [31:0] w;
    logic [31:0] r;
    es_to_ms_valid  = v;
    es_to_ms_bus    = b;
    ws_allowin      = wa;
    data_sram_rdata = rd;
    reset           = rst;
    #1;
    w = m_locked ? m_word : rd;
    r = ref_result(m_bus[76:70], m_bus[108:77], m_bus[63:32], w);
    exp_q.push_back(r);
    check("ms_to_ws_valid", 70'(ms_to_ws_valid), 70'(m_valid));
    check("ms_allowin", 70'(ms_allowin), 70'(!m_valid || wa));
    check("fwd_valid", 70'(ms_fwd_bus[37]), 70'(m_valid && m_bus[69]));
    if (m_valid) begin
      check("ws_bus", 70'(ms_to_ws_bus), {m_bus[69], m_bus[68:64], exp_q.pop_front(), m_bus[31:0]});
      check("fwd_data", 70'(ms_fwd_bus[36:0]), 70'({m_bus[68:64], r}));
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  // advance one clock edge and update the model with the inputs just applied
  task automatic tick();
    logic allow;
    @(posedge clk);
    allow = !m_valid || ws_allowin;
    if (reset) begin
      m_valid  = 1'b0;
      m_bus    = '0;
      m_locked = 1'b0;
      m_word   = '0;
    end else begin
      if (es_to_ms_valid && allow) begin
        m_bus    = es_to_ms_bus;
        m_locked = 1'b0;
      end else if (m_valid && !ws_allowin && !m_locked) begin
        m_locked = 1'b1;
        m_word   = data_sram_rdata;
      end
      if (allow) m_valid = es_to_ms_valid;
    end
    @(negedge clk);
  endtask

  task automatic load_check(input string tag, input logic [6:0] ld, input logic [31:0] rt,
                            input logic [31:0] res, input logic [31:0] rd,
                            input logic [31:0] expect_v);
    drive(1'b1, mk_bus(rt, ld, 1'b1, 5'd7, res, 32'h0040_0000), 1'b1, $urandom, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, rd, 1'b0);
    check(tag, 70'(ms_to_ws_bus[63:32]), 70'(expect_v));
    tick();
  endtask

  logic [6:0] ld_tab [8];

  initial begin
    ld_tab = '{LD_LW, LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LWL, LD_LWR, LD_NON};
    m_valid = 1'b0; m_bus = '0; m_locked = 1'b0; m_word = '0;
    es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b0;
    data_sram_rdata = '0; reset = 1'b1;
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 32'h1357_9BDF, 1'b0);
    check("reset_valid", 70'(ms_to_ws_valid), 70'(0));
    check("reset_allowin", 70'(ms_allowin), 70'(1));
    check("reset_fwd", 70'(ms_fwd_bus), 70'(0));
    tick();

    // byte / halfword extension
    load_check("lb_pos0",  LD_LB,  32'h0, 32'h100, 32'h8844_22F1, 32'hFFFF_FFF1);
    load_check("lbu_pos3", LD_LBU, 32'h0, 32'h103, 32'h8844_22F1, 32'h0000_0088);
    load_check("lh_pos2",  LD_LH,  32'h0, 32'h102, 32'h8844_22F1, 32'hFFFF_8844);
    load_check("lhu_pos0", LD_LHU, 32'h0, 32'h100, 32'h8844_22F1, 32'h0000_22F1);
    // unaligned
    load_check("lwl_pos1", LD_LWL, 32'h1122_3344, 32'h201, 32'hAABB_CCDD, 32'hCCDD_3344);
    load_check("lwl_pos3", LD_LWL, 32'h1122_3344, 32'h203, 32'hAABB_CCDD, 32'hAABB_CCDD);
    load_check("lwr_pos2", LD_LWR, 32'h1122_3344, 32'h202, 32'hAABB_CCDD, 32'h1122_AABB);
    load_check("lwr_pos0", LD_LWR, 32'h1122_3344, 32'h200, 32'hAABB_CCDD, 32'hAABB_CCDD);

    // stall with changing rdata
    drive(1'b1, mk_bus(32'h0, LD_LW, 1'b1, 5'd9, 32'h300, 32'h100), 1'b1, 32'h0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0, (i == 0) ? 32'h1234_5678 : 32'hDEAD_BEEF, 1'b0);
      check("stall_result", 70'(ms_to_ws_bus[63:32]), 70'(32'h1234_5678));
      check("stall_allowin", 70'(ms_allowin), 70'(0));
      tick();
    end
    drive(1'b0, '0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    check("stall_release", 70'(ms_to_ws_bus[63:32]), 70'(32'h1234_5678));
    tick();

    // back-to-back
    drive(1'b1, mk_bus(32'h0, LD_NON, 1'b1, 5'd3, 32'h5, 32'h200), 1'b1, 32'h0, 1'b0);
    tick();
    drive(1'b1, mk_bus(32'h0, LD_LW, 1'b1, 5'd4, 32'h400, 32'h204), 1'b1, 32'h77, 1'b0);
    check("b2b_fwd0", 70'(ms_fwd_bus), 70'({1'b1, 5'd3, 32'h5}));
    tick();
    drive(1'b0, '0, 1'b1, 32'h9, 1'b0);
    check("b2b_fwd1", 70'(ms_fwd_bus), 70'({1'b1, 5'd4, 32'h9}));
    tick();

    // bubble and store
    drive(1'b0, '0, 1'b1, 32'h9, 1'b0);
    check("bubble_valid", 70'(ms_to_ws_valid), 70'(0));
    check("bubble_fwd_valid", 70'(ms_fwd_bus[37]), 70'(0));
    tick();
    drive(1'b1, mk_bus(32'h55, LD_NON, 1'b0, 5'd0, 32'hABCD_0010, 32'h208), 1'b1, 32'h0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 32'h6666_6666, 1'b0);
    check("store_fwd_valid", 70'(ms_fwd_bus[37]), 70'(0));
    check("store_result", 70'(ms_to_ws_bus[63:32]), 70'(32'hABCD_0010));
    tick();

    // reset during a stalled load
    drive(1'b1, mk_bus(32'h0, LD_LW, 1'b1, 5'd12, 32'h500, 32'h20C), 1'b1, 32'h0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 32'hCAFE_F00D, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 32'h1111_1111, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 32'h2222_2222, 1'b0);
    check("rst_mid_valid", 70'(ms_to_ws_valid), 70'(0));
    check("rst_mid_allowin", 70'(ms_allowin), 70'(1));
    check("rst_mid_fwd", 70'(ms_fwd_bus), 70'(0));
    tick();
    load_check("post_rst_lw", LD_LW, 32'h0, 32'h600, 32'h5A5A_5A5A, 32'h5A5A_5A5A);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0),
            mk_bus($urandom, ld_tab[$urandom_range(0, 7)], 1'($urandom), 5'($urandom),
                   $urandom, $urandom),
            1'($urandom_range(0, 9) < 7), $urandom, 1'($urandom_range(0, 99) < 2));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
